// File: rtl/adma2_descriptor_controller.sv
// ---------------------------------------------------------------------------
// adma2_descriptor_controller
//
// Walks an ADMA2 descriptor table in system memory. Each 96-bit descriptor is
// fetched and decoded. A tran descriptor launches one transfer on the DMA
// datapath. A link descriptor redirects the table pointer. nop and reserved
// descriptors just advance the pointer. The block also records the first
// error and raises the done and interrupt pulses.
//
// Ports
//   CLK, RESET               clock (rising edge), async active-low reset
//   STOP                     stop request level
//   command_reg_write        start at desc_base (pulse)
//   command_reg_continue     resume after a stop (pulse)
//   direction                1 = card-to-memory, latched at start
//   desc_base                descriptor table base address
//   desc_req/desc_addr       descriptor read request and address
//   desc_ack/desc_data       descriptor data valid pulse and payload
//   xfer_start/addr/len/dir  transfer launch pulse and held parameters
//   xfer_done                datapath completion pulse
//   busy, adma_state         engine activity and current state
//   adma_done, adma_int      End-completion and Int pulses
//   adma_error, adma_err_state  sticky error and the state it occurred in
// ---------------------------------------------------------------------------
module adma2_descriptor_controller #(
    parameter int DESC_BYTES  = 12,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STOP,
    input  logic        command_reg_write,
    input  logic        command_reg_continue,
    input  logic        direction,
    input  logic [63:0] desc_base,
    output logic        desc_req,
    output logic [63:0] desc_addr,
    input  logic        desc_ack,
    input  logic [95:0] desc_data,
    output logic        xfer_start,
    output logic [63:0] xfer_addr,
    output logic [16:0] xfer_len,
    output logic        xfer_dir,
    input  logic        xfer_done,
    output logic        busy,
    output logic [1:0]  adma_state,
    output logic        adma_done,
    output logic        adma_int,
    output logic        adma_error,
    output logic [1:0]  adma_err_state
);

    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_FDS  = 2'd1;
    localparam logic [1:0] ST_CADR = 2'd2;
    localparam logic [1:0] ST_TFR  = 2'd3;

    localparam logic [63:0] DESC_STRIDE = 64'(DESC_BYTES);
    // The counter value at which the last allowed wait cycle is running.
    localparam logic [7:0]  ACK_LIMIT   = 8'(ACK_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [63:0] desc_ptr_q, desc_ptr_d;
    logic [95:0] desc_q, desc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        paused_q, paused_d;
    logic        stop_pend_q, stop_pend_d;
    logic        dir_q, dir_d;
    logic        xfer_start_q, xfer_start_d;
    logic [63:0] xfer_addr_q, xfer_addr_d;
    logic [16:0] xfer_len_q, xfer_len_d;
    logic        done_q, done_d;
    logic        int_q, int_d;
    logic        err_q, err_d;
    logic [1:0]  err_state_q, err_state_d;

    // Fields of the latched descriptor.
    logic [63:0] d_addr;
    logic [15:0] d_len;
    logic        d_valid, d_end, d_int;
    logic [1:0]  d_act;

    assign d_addr  = desc_q[95:32];
    assign d_len   = desc_q[31:16];
    assign d_valid = desc_q[0];
    assign d_end   = desc_q[1];
    assign d_int   = desc_q[2];
    assign d_act   = desc_q[5:4];

    // Attribute bits that carry no meaning for this engine.
    logic unused_attr_bits;
    assign unused_attr_bits = ^{desc_q[15:6], desc_q[3]};

    always_comb begin
        state_d      = state_q;
        desc_ptr_d   = desc_ptr_q;
        desc_d       = desc_q;
        cnt_d        = 8'd0;
        paused_d     = paused_q;
        stop_pend_d  = stop_pend_q;
        dir_d        = dir_q;
        xfer_start_d = 1'b0;
        xfer_addr_d  = xfer_addr_q;
        xfer_len_d   = xfer_len_q;
        done_d       = 1'b0;
        int_d        = 1'b0;
        err_d        = err_q;
        err_state_d  = err_state_q;

        case (state_q)
            ST_STOP: begin
                // A stop request in the same cycle suppresses both start pulses.
                if (!STOP) begin
                    if (command_reg_write) begin
                        desc_ptr_d  = desc_base;
                        dir_d       = direction;
                        err_d       = 1'b0;
                        err_state_d = 2'd0;
                        paused_d    = 1'b0;
                        state_d     = ST_FDS;
                    end else if (command_reg_continue && paused_q) begin
                        paused_d = 1'b0;
                        state_d  = ST_FDS;
                    end
                end
            end

            ST_FDS: begin
                if (STOP) begin
                    paused_d = 1'b1;
                    state_d  = ST_STOP;
                end else if (desc_ack) begin
                    desc_d  = desc_data;
                    state_d = ST_CADR;
                end else if (cnt_q == ACK_LIMIT) begin
                    err_d       = 1'b1;
                    err_state_d = ST_FDS;
                    state_d     = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_CADR: begin
                if (!d_valid) begin
                    err_d       = 1'b1;
                    err_state_d = ST_CADR;
                    state_d     = ST_STOP;
                end else if (d_act == 2'b10) begin
                    desc_ptr_d   = desc_ptr_q + DESC_STRIDE;
                    xfer_addr_d  = d_addr;
                    // A length field of zero stands for the full 64 KiB.
                    xfer_len_d   = (d_len == 16'd0) ? 17'h10000 : {1'b0, d_len};
                    xfer_start_d = 1'b1;
                    stop_pend_d  = STOP;
                    state_d      = ST_TFR;
                end else begin
                    if (d_act == 2'b11) begin
                        desc_ptr_d = d_addr;
                    end else begin
                        desc_ptr_d = desc_ptr_q + DESC_STRIDE;
                    end
                    if (d_end) begin
                        done_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (STOP) begin
                        paused_d = 1'b1;
                        state_d  = ST_STOP;
                    end else begin
                        state_d = ST_FDS;
                    end
                end
            end

            default: begin // ST_TFR
                // A stop never cuts a transfer short; it takes effect at completion.
                if (xfer_done) begin
                    int_d       = d_int;
                    stop_pend_d = 1'b0;
                    if (d_end) begin
                        done_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (stop_pend_q || STOP) begin
                        paused_d = 1'b1;
                        state_d  = ST_STOP;
                    end else begin
                        state_d = ST_FDS;
                    end
                end else if (STOP) begin
                    stop_pend_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_STOP;
            desc_ptr_q   <= 64'd0;
            desc_q       <= 96'd0;
            cnt_q        <= 8'd0;
            paused_q     <= 1'b0;
            stop_pend_q  <= 1'b0;
            dir_q        <= 1'b0;
            xfer_start_q <= 1'b0;
            xfer_addr_q  <= 64'd0;
            xfer_len_q   <= 17'd0;
            done_q       <= 1'b0;
            int_q        <= 1'b0;
            err_q        <= 1'b0;
            err_state_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            desc_ptr_q   <= desc_ptr_d;
            desc_q       <= desc_d;
            cnt_q        <= cnt_d;
            paused_q     <= paused_d;
            stop_pend_q  <= stop_pend_d;
            dir_q        <= dir_d;
            xfer_start_q <= xfer_start_d;
            xfer_addr_q  <= xfer_addr_d;
            xfer_len_q   <= xfer_len_d;
            done_q       <= done_d;
            int_q        <= int_d;
            err_q        <= err_d;
            err_state_q  <= err_state_d;
        end
    end

    assign desc_req       = (state_q == ST_FDS);
    assign desc_addr      = desc_ptr_q;
    assign xfer_start     = xfer_start_q;
    assign xfer_addr      = xfer_addr_q;
    assign xfer_len       = xfer_len_q;
    assign xfer_dir       = dir_q;
    assign busy           = (state_q != ST_STOP);
    assign adma_state     = state_q;
    assign adma_done      = done_q;
    assign adma_int       = int_q;
    assign adma_error     = err_q;
    assign adma_err_state = err_state_q;

endmodule

// File: tb/tb_adma2_descriptor_controller.sv
// ---------------------------------------------------------------------------
// Testbench for adma2_descriptor_controller. A descriptor memory and a
// transfer datapath with random latencies respond to the engine. Every
// fetch, transfer launch, interrupt and done pulse is recorded and compared
// against tables of expected results. The tables are built from the ADMA2
// walking rules.
// ---------------------------------------------------------------------------
module tb_adma2_descriptor_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stop_i, cmd_write, cmd_cont, direction;
    logic [63:0] desc_base;
    logic        desc_req;
    logic [63:0] desc_addr;
    logic        desc_ack;
    logic [95:0] desc_data;
    logic        xfer_start;
    logic [63:0] xfer_addr;
    logic [16:0] xfer_len;
    logic        xfer_dir;
    logic        xfer_done;
    logic        busy;
    logic [1:0]  adma_state;
    logic        adma_done, adma_int, adma_error;
    logic [1:0]  adma_err_state;

    always #5 clk = ~clk;

    adma2_descriptor_controller #(.DESC_BYTES(12), .ACK_TIMEOUT(255)) dut (
        .CLK(clk), .RESET(rst_n), .STOP(stop_i),
        .command_reg_write(cmd_write), .command_reg_continue(cmd_cont),
        .direction(direction), .desc_base(desc_base),
        .desc_req(desc_req), .desc_addr(desc_addr),
        .desc_ack(desc_ack), .desc_data(desc_data),
        .xfer_start(xfer_start), .xfer_addr(xfer_addr), .xfer_len(xfer_len),
        .xfer_dir(xfer_dir), .xfer_done(xfer_done),
        .busy(busy), .adma_state(adma_state), .adma_done(adma_done),
        .adma_int(adma_int), .adma_error(adma_error), .adma_err_state(adma_err_state)
    );

    typedef struct {
        logic [63:0] addr;
        logic [16:0] len;
        logic        dir;
    } xfer_t;

    typedef struct {
        logic [63:0] addr;
        logic [15:0] len;
        logic [15:0] attr;
        int          nfetch;
        logic [63:0] fetch2;
        int          nxfer;
        logic [16:0] xlen;
        int          nint;
        int          ndone;
        logic        err;
        logic [1:0]  es;
    } vec_t;

    // Recorded activity (written only by the environment process).
    logic [63:0] fetch_q[$];
    xfer_t       xfer_q[$];
    int          int_cnt = 0;
    int          done_cnt = 0;

    logic [95:0] mem [logic [63:0]];
    bit          desc_en = 1'b1;
    bit          xfer_en = 1'b1;
    int          desc_max_lat = 0;
    int          xfer_max_lat = 0;

    int checks_total = 0;
    int checks_passed = 0;

    int  env_dlat = 0;
    int  env_xlat = 0;
    bit  env_xpend = 1'b0;

    function automatic logic [95:0] mk(logic [63:0] a, logic [15:0] l, logic [15:0] attr);
        return {a, l, attr};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Descriptor memory, transfer datapath and output monitor, all at negedge.
    initial begin
        desc_ack  = 1'b0;
        xfer_done = 1'b0;
        desc_data = '0;
        forever begin
            @(negedge clk);
            desc_ack  = 1'b0;
            xfer_done = 1'b0;
            if (rst_n !== 1'b1) begin
                env_xpend = 1'b0;
                env_dlat  = 0;
            end else begin
                if (xfer_start) begin
                    xfer_q.push_back('{xfer_addr, xfer_len, xfer_dir});
                    env_xpend = 1'b1;
                    env_xlat  = int'($urandom_range(0, xfer_max_lat));
                end
                if (adma_int)  int_cnt++;
                if (adma_done) done_cnt++;
                if (desc_req && desc_en) begin
                    if (env_dlat == 0) begin
                        desc_ack  = 1'b1;
                        desc_data = mem.exists(desc_addr) ? mem[desc_addr] : 96'd0;
                        fetch_q.push_back(desc_addr);
                        env_dlat  = int'($urandom_range(0, desc_max_lat));
                    end else begin
                        env_dlat--;
                    end
                end
                if (env_xpend && xfer_en) begin
                    if (env_xlat == 0) begin
                        xfer_done = 1'b1;
                        env_xpend = 1'b0;
                    end else begin
                        env_xlat--;
                    end
                end
            end
        end
    end

    task automatic pulse_write();
        @(negedge clk);
        cmd_write = 1'b1;
        @(negedge clk);
        cmd_write = 1'b0;
    endtask

    task automatic pulse_cont();
        @(negedge clk);
        cmd_cont = 1'b1;
        @(negedge clk);
        cmd_cont = 1'b0;
    endtask

    task automatic wait_idle(string name, int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle"}, busy, 0);
        @(negedge clk);
        #1;
    endtask

    // Global time limit.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[9];
        int          f0, x0, i0, d0, n;
        logic [63:0] exp_f[$];
        xfer_t       exp_x[$];
        int          exp_i;
        bit          exp_d, exp_e;
        logic [63:0] ptr, base, a;
        logic [15:0] l, attr;
        logic [1:0]  act;
        int          cnt, kind;
        bit          last, ib;
        logic        d;

        rst_n     = 1'b0;
        stop_i    = 1'b0;
        cmd_write = 1'b0;
        cmd_cont  = 1'b0;
        direction = 1'b0;
        desc_base = 64'h1000;
        repeat (3) @(negedge clk);

        check("reset busy", busy, 0);
        check("reset state", adma_state, 0);
        check("reset desc_req", desc_req, 0);
        check("reset desc_addr", desc_addr, 0);
        check("reset xfer_start", xfer_start, 0);
        check("reset xfer_len", xfer_len, 0);
        check("reset xfer_addr", xfer_addr, 0);
        check("reset error", adma_error, 0);
        check("reset done/int", {adma_done, adma_int, adma_err_state}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-descriptor decode table. 0x100C and 0x3000 hold nop+End terminators.
        vecs[0] = '{64'h8000,     16'h0200, 16'h0023, 1, 64'h0,    1, 17'd512,     0, 1, 1'b0, 2'd0};
        vecs[1] = '{64'h0,        16'h0000, 16'h0000, 1, 64'h0,    0, 17'd0,       0, 0, 1'b1, 2'd2};
        vecs[2] = '{64'hA000,     16'h0000, 16'h0025, 2, 64'h100C, 1, 17'h10000,   1, 1, 1'b0, 2'd0};
        vecs[3] = '{64'h3000,     16'h0000, 16'h0031, 2, 64'h3000, 0, 17'd0,       0, 1, 1'b0, 2'd0};
        vecs[4] = '{64'h0,        16'h0000, 16'h0003, 1, 64'h0,    0, 17'd0,       0, 1, 1'b0, 2'd0};
        vecs[5] = '{64'h5555,     16'h0010, 16'h0011, 2, 64'h100C, 0, 17'd0,       0, 1, 1'b0, 2'd0};
        vecs[6] = '{64'hDEAD0000, 16'h0001, 16'h0027, 1, 64'h0,    1, 17'd1,       1, 1, 1'b0, 2'd0};
        vecs[7] = '{64'h8000,     16'h0200, 16'h0022, 1, 64'h0,    0, 17'd0,       0, 0, 1'b1, 2'd2};
        vecs[8] = '{64'h0,        16'h0000, 16'h0007, 1, 64'h0,    0, 17'd0,       0, 1, 1'b0, 2'd0};

        for (int i = 0; i < 9; i++) begin
            mem.delete();
            mem[64'h1000] = mk(vecs[i].addr, vecs[i].len, vecs[i].attr);
            mem[64'h100C] = mk(64'h0, 16'h0, 16'h0003);
            mem[64'h3000] = mk(64'h0, 16'h0, 16'h0003);
            desc_base = 64'h1000;
            direction = i[0];
            f0 = fetch_q.size(); x0 = xfer_q.size(); i0 = int_cnt; d0 = done_cnt;
            pulse_write();
            wait_idle("vec", 300);
            $display("vec %0d attr=0x%04h: fetches=%0d xfers=%0d ints=%0d done=%0d err=%0b/%0d", i,
                     vecs[i].attr, fetch_q.size() - f0, xfer_q.size() - x0, int_cnt - i0,
                     done_cnt - d0, adma_error, adma_err_state);
            check("vec fetch count", fetch_q.size() - f0, vecs[i].nfetch);
            if (fetch_q.size() > f0) check("vec fetch0 addr", fetch_q[f0], 64'h1000);
            if (vecs[i].nfetch > 1 && fetch_q.size() > f0 + 1) check("vec fetch1 addr", fetch_q[f0 + 1], vecs[i].fetch2);
            check("vec xfer count", xfer_q.size() - x0, vecs[i].nxfer);
            if (vecs[i].nxfer > 0 && xfer_q.size() > x0) begin
                check("vec xfer addr", xfer_q[x0].addr, vecs[i].addr);
                check("vec xfer len", xfer_q[x0].len, vecs[i].xlen);
                check("vec xfer dir", xfer_q[x0].dir, i[0]);
            end
            check("vec int count", int_cnt - i0, vecs[i].nint);
            check("vec done count", done_cnt - d0, vecs[i].ndone);
            check("vec error", adma_error, vecs[i].err);
            check("vec err_state", adma_err_state, vecs[i].es);
            check("vec state", adma_state, 0);
        end

        // Three-entry table with a link into a second region.
        mem.delete();
        mem[64'h1000] = mk(64'h0,    16'h0000, 16'h0001);
        mem[64'h100C] = mk(64'hA000, 16'h0000, 16'h0025);
        mem[64'h1018] = mk(64'h2000, 16'h0000, 16'h0031);
        mem[64'h2000] = mk(64'hB000, 16'h0040, 16'h0023);
        desc_max_lat = 2; xfer_max_lat = 2;
        f0 = fetch_q.size(); x0 = xfer_q.size(); i0 = int_cnt; d0 = done_cnt;
        pulse_write();
        wait_idle("chain", 500);
        $display("chain: fetches=%0d xfers=%0d ints=%0d done=%0d", fetch_q.size() - f0,
                 xfer_q.size() - x0, int_cnt - i0, done_cnt - d0);
        check("chain fetch count", fetch_q.size() - f0, 4);
        if (fetch_q.size() >= f0 + 4) begin
            check("chain fetch0", fetch_q[f0],     64'h1000);
            check("chain fetch1", fetch_q[f0 + 1], 64'h100C);
            check("chain fetch2", fetch_q[f0 + 2], 64'h1018);
            check("chain fetch3", fetch_q[f0 + 3], 64'h2000);
        end
        check("chain xfer count", xfer_q.size() - x0, 2);
        if (xfer_q.size() >= x0 + 2) begin
            check("chain xfer0 len", xfer_q[x0].len, 17'h10000);
            check("chain xfer0 addr", xfer_q[x0].addr, 64'hA000);
            check("chain xfer1 len", xfer_q[x0 + 1].len, 17'd64);
            check("chain xfer1 addr", xfer_q[x0 + 1].addr, 64'hB000);
        end
        check("chain ints", int_cnt - i0, 1);
        check("chain done", done_cnt - d0, 1);
        desc_max_lat = 0; xfer_max_lat = 0;

        // Withheld acknowledge: error after exactly 255 waiting cycles.
        mem.delete();
        desc_en = 1'b0;
        pulse_write();
        n = 0;
        while (adma_state == 2'd1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        $display("timeout: fds cycles=%0d err=%0b err_state=%0d", n, adma_error, adma_err_state);
        check("timeout fds cycles", n, 255);
        check("timeout error", adma_error, 1);
        check("timeout err_state", adma_err_state, 1);
        check("timeout state", adma_state, 0);
        desc_en = 1'b1;
        mem[64'h1000] = mk(64'h8000, 16'h0200, 16'h0023);
        d0 = done_cnt;
        pulse_write();
        check("restart clears error", adma_error, 0);
        check("restart clears err_state", adma_err_state, 0);
        wait_idle("restart", 300);
        check("restart done", done_cnt - d0, 1);

        // STOP together with the start pulse: the start is suppressed.
        @(negedge clk);
        stop_i = 1'b1; cmd_write = 1'b1;
        @(negedge clk);
        stop_i = 1'b0; cmd_write = 1'b0;
        check("stop beats write", busy, 0);
        // Continue without a prior pause is ignored.
        pulse_cont();
        check("continue unpaused ignored", busy, 0);

        // STOP during a transfer: the transfer finishes, then the engine pauses.
        mem.delete();
        mem[64'h1000] = mk(64'h4000, 16'h0100, 16'h0021);
        mem[64'h100C] = mk(64'h5000, 16'h0080, 16'h0023);
        xfer_en = 1'b0;
        f0 = fetch_q.size(); x0 = xfer_q.size(); d0 = done_cnt;
        pulse_write();
        n = 0;
        while (xfer_q.size() == x0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        stop_i = 1'b1;
        repeat (3) @(negedge clk);
        check("stop keeps transfer", adma_state, 3);
        stop_i = 1'b0;
        @(negedge clk);
        xfer_en = 1'b1;
        wait_idle("stop mid tfr", 100);
        check("paused xfer count", xfer_q.size() - x0, 1);
        check("paused no done", done_cnt - d0, 0);
        check("paused state", adma_state, 0);
        f0 = fetch_q.size();
        pulse_cont();
        wait_idle("continue", 300);
        $display("continue: fetches=%0d xfers=%0d done=%0d", fetch_q.size() - f0,
                 xfer_q.size() - x0, done_cnt - d0);
        check("continue fetch count", fetch_q.size() - f0, 1);
        if (fetch_q.size() > f0) check("continue fetch addr", fetch_q[f0], 64'h100C);
        check("continue xfer count", xfer_q.size() - x0, 2);
        check("continue done", done_cnt - d0, 1);

        // STOP while waiting for a descriptor: the pointer is retained.
        desc_en = 1'b0;
        pulse_write();
        repeat (4) @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        check("stop in fds busy", busy, 0);
        desc_en = 1'b1;
        f0 = fetch_q.size(); d0 = done_cnt;
        pulse_cont();
        wait_idle("fds resume", 300);
        if (fetch_q.size() > f0) check("fds resume addr", fetch_q[f0], 64'h1000);
        else check("fds resume fetch count", fetch_q.size() - f0, 1);
        check("fds resume done", done_cnt - d0, 1);

        // Asynchronous reset while the transfer launch pulse is high.
        mem.delete();
        mem[64'h1000] = mk(64'h8000, 16'h0200, 16'h0023);
        xfer_en = 1'b0;
        pulse_write();
        n = 0;
        while (!xfer_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset test launch seen", xfer_start, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset xfer_start", xfer_start, 0);
        check("async reset busy", busy, 0);
        check("async reset state", adma_state, 0);
        check("async reset desc_req", desc_req, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer_en = 1'b1;
        f0 = fetch_q.size(); d0 = done_cnt;
        pulse_write();
        wait_idle("post reset", 300);
        if (fetch_q.size() > f0) check("post reset fetch addr", fetch_q[f0], 64'h1000);
        else check("post reset fetch count", fetch_q.size() - f0, 1);
        check("post reset done", done_cnt - d0, 1);

        // Randomised tables checked against the descriptor-walking rules.
        for (int it = 0; it < 40; it++) begin
            mem.delete();
            exp_f.delete();
            exp_x.delete();
            exp_i = 0; exp_d = 1'b0; exp_e = 1'b0;
            base = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFF4 : {$urandom, $urandom};
            ptr  = base;
            d    = 1'($urandom_range(0, 1));
            cnt  = int'($urandom_range(1, 6));
            for (int i = 0; i < cnt; i++) begin
                last = (i == cnt - 1);
                kind = int'($urandom_range(0, 9));
                ib   = 1'($urandom_range(0, 1));
                a    = {$urandom, $urandom};
                l    = 16'($urandom);
                if ($urandom_range(0, 5) == 0) l = 16'h0;
                exp_f.push_back(ptr);
                if (kind == 0) begin
                    mem[ptr] = mk(a, l, 16'($urandom) & 16'hFFFE);
                    exp_e = 1'b1;
                    break;
                end
                if (last && (kind == 4 || kind == 5)) kind = 6;
                if (kind <= 2)      act = 2'b00;
                else if (kind == 3) act = 2'b01;
                else if (kind <= 5) act = 2'b11;
                else                act = 2'b10;
                attr = (16'($urandom) & 16'hFFC8) | (16'(act) << 4) | (16'(ib) << 2)
                     | (16'(last) << 1) | 16'h0001;
                mem[ptr] = mk(a, l, attr);
                if (act == 2'b10) begin
                    exp_x.push_back('{a, (l == 16'h0) ? 17'h10000 : {1'b0, l}, d});
                    if (ib) exp_i++;
                end
                if (act == 2'b11) ptr = a;
                else              ptr = ptr + 64'd12;
                if (last) exp_d = 1'b1;
            end
            desc_base    = base;
            direction    = d;
            desc_max_lat = int'($urandom_range(0, 3));
            xfer_max_lat = int'($urandom_range(0, 3));
            f0 = fetch_q.size(); x0 = xfer_q.size(); i0 = int_cnt; d0 = done_cnt;
            pulse_write();
            wait_idle("rand", 2000);
            $display("rand %0d base=0x%0h: fetches=%0d/%0d xfers=%0d/%0d ints=%0d done=%0d err=%0b",
                     it, base, fetch_q.size() - f0, exp_f.size(), xfer_q.size() - x0,
                     exp_x.size(), int_cnt - i0, done_cnt - d0, adma_error);
            check("rand fetch count", fetch_q.size() - f0, exp_f.size());
            for (int k = 0; k < exp_f.size() && f0 + k < fetch_q.size(); k++)
                check("rand fetch addr", fetch_q[f0 + k], exp_f[k]);
            check("rand xfer count", xfer_q.size() - x0, exp_x.size());
            for (int k = 0; k < exp_x.size() && x0 + k < xfer_q.size(); k++) begin
                check("rand xfer addr", xfer_q[x0 + k].addr, exp_x[k].addr);
                check("rand xfer len", xfer_q[x0 + k].len, exp_x[k].len);
                check("rand xfer dir", xfer_q[x0 + k].dir, exp_x[k].dir);
            end
            check("rand ints", int_cnt - i0, exp_i);
            check("rand done", done_cnt - d0, exp_d ? 1 : 0);
            check("rand error", adma_error, exp_e);
            check("rand err_state", adma_err_state, exp_e ? 2 : 0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
